// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time instruction memory loader.
// Imported by the loader top and its byte assembler.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } loader_state_e;

    localparam int LOADER_LEN_BYTES = 4;

    localparam logic [1:0] LAST_BYTE = 2'(LOADER_LEN_BYTES - 1);

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Little-endian byte-to-word assembler shared by the length field and payload.
// word/word_complete are combinational so the 4th byte is usable on its own edge.
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] sr_q, sr_d;

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clr) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (byte_valid) begin
            // Right shift: the first byte received ends up in bits [7:0].
            sr_d  = {byte_in, sr_q[31:8]};
            cnt_d = cnt_q + 2'd1;
        end
    end

    assign word          = {byte_in, sr_q[31:8]};
    assign word_complete = byte_valid && (cnt_q == LAST_BYTE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed, XOR-checked image into instruction
// memory and keeps the core in reset until the image verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        load_done,
    output logic        load_error
);

    localparam int IDX_W = $clog2(MEM_WORDS + 1);

    loader_state_e state_q, state_d;

    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             len_pend_q, len_pend_d;
    logic             len_over_q, len_over_d;
    logic [7:0]       xor_q, xor_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic        accept;
    logic        asm_valid;
    logic        asm_clr;
    logic        asm_complete;
    logic [31:0] asm_word;

    // Ready depends only on registered state to keep the handshake loop-free.
    always_comb begin
        rx_ready = 1'b0;
        unique case (state_q)
            LEN:     rx_ready = !len_pend_q;
            DATA:    rx_ready = 1'b1;
            CHK:     rx_ready = 1'b1;
            default: rx_ready = 1'b0;
        endcase
        rx_ready = rx_ready && rst_n;
    end

    assign accept    = rx_valid && rx_ready;
    assign asm_valid = accept && ((state_q == LEN) || (state_q == DATA));

    byte_word_assembler u_asm (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (asm_clr),
        .byte_valid    (asm_valid),
        .byte_in       (rx_data),
        .word          (asm_word),
        .word_complete (asm_complete)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        len_pend_d = len_pend_q;
        len_over_d = len_over_q;
        xor_d      = xor_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        imem_we    = 1'b0;
        asm_clr    = 1'b0;

        unique case (state_q)
            LEN: begin
                if (len_pend_q) begin
                    // Decision cycle: rx_ready is low while the count is judged.
                    len_pend_d = 1'b0;
                    asm_clr    = 1'b1;
                    idx_d      = '0;
                    xor_d      = '0;
                    if (len_over_q) begin
                        state_d = ERROR;
                    end else if (len_q == '0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA;
                    end
                end else if (asm_complete) begin
                    len_pend_d = 1'b1;
                    len_over_d = asm_word > 32'(MEM_WORDS);
                    len_d      = asm_word[IDX_W-1:0];
                end
            end
            DATA: begin
                if (accept) begin
                    xor_d = xor_q ^ rx_data;
                    if (asm_complete) begin
                        wdata_d = asm_word;
                        addr_d  = BASE_ADDR + (32'(idx_q) << 2);
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                idx_d   = idx_q + 1'b1;
                state_d = (idx_d == len_q) ? CHK : DATA;
            end
            CHK: begin
                if (accept) begin
                    state_d = (rx_data == xor_q) ? DONE : ERROR;
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    assign done_d = done_q || (state_d == DONE);
    assign err_d  = err_q || (state_d == ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LEN;
            len_q      <= '0;
            idx_q      <= '0;
            len_pend_q <= 1'b0;
            len_over_q <= 1'b0;
            xor_q      <= '0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            len_pend_q <= len_pend_d;
            len_over_q <= len_over_d;
            xor_q      <= xor_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign load_done  = done_q;
    assign load_error = err_q;
    assign core_rst_n = done_q && rst_n;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed images, expected writes queued
// by stimulus and checked by an independent write monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        load_done;
    logic        load_error;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] img[$];
    int         gaps[9] = '{3, 0, 7, 1, 5, 2, 6, 4, 0};
    int         tests = 0;
    int         fails = 0;
    int         wr_cnt = 0;
    int         base;

    always #5 clk = ~clk;

    imem_loader #(
        .MEM_WORDS (1024),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .load_done  (load_done),
        .load_error (load_error)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Write monitor: every imem_we pulse must match the next queued write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (load_done || load_error)
                chk("done_err_excl", 32'(load_done && load_error), 32'd0);
            if (imem_we) begin
                wr_cnt++;
                chk("rdy_in_write", 32'(rx_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", imem_addr, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", imem_addr, mon_e.addr);
                    chk("wr_data", imem_wdata, mon_e.data);
                end
            end
        end
    end

    task automatic do_reset();
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        logic acc;
        rx_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                rx_valid = 1'b0;
                return;
            end
        end
        rx_valid = 1'b0;
        chk("send_timeout", 32'(b), 32'hFFFF_FFFF);
    endtask

    task automatic send_img(input bit gapped);
        for (int i = 0; i < img.size(); i++)
            send(img[i], gapped ? gaps[i % 9] : 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values while rst_n is held low
        #12;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_imem_wdata", imem_wdata, 32'h0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        do_reset();
        chk("len_ready", 32'(rx_ready), 32'd1);

        // Good 2-word image: 13^93^10 = 90
        base = wr_cnt;
        exp_q.push_back('{32'h0, 32'h0000_0013});
        exp_q.push_back('{32'h4, 32'h0010_0093});
        img = '{8'h02, 8'h00, 8'h00, 8'h00,
                8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
        send_img(1'b0);
        chk("good_done_early", 32'(load_done), 32'd0);
        chk("good_core_early", 32'(core_rst_n), 32'd0);
        send(8'h90, 0);
        chk("good_done", 32'(load_done), 32'd1);
        chk("good_core_rst", 32'(core_rst_n), 32'd1);
        chk("good_err", 32'(load_error), 32'd0);
        chk("good_writes", 32'(wr_cnt - base), 32'd2);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(negedge clk);
        chk("done_rdy_low", 32'(rx_ready), 32'd0);
        idle(2);
        rx_valid = 1'b0;
        chk("done_sticky", 32'(load_done), 32'd1);
        chk("sb_empty_good", 32'(exp_q.size()), 32'd0);

        // Same payload, bad checksum
        do_reset();
        base = wr_cnt;
        exp_q.push_back('{32'h0, 32'h0000_0013});
        exp_q.push_back('{32'h4, 32'h0010_0093});
        send_img(1'b0);
        send(8'h81, 0);
        idle(2);
        chk("badck_err", 32'(load_error), 32'd1);
        chk("badck_done", 32'(load_done), 32'd0);
        chk("badck_core", 32'(core_rst_n), 32'd0);
        chk("badck_rdy", 32'(rx_ready), 32'd0);
        chk("badck_writes", 32'(wr_cnt - base), 32'd2);

        // N = 1025 exceeds depth
        do_reset();
        base = wr_cnt;
        img = '{8'h01, 8'h04, 8'h00, 8'h00};
        send_img(1'b0);
        idle(3);
        chk("ovf_err", 32'(load_error), 32'd1);
        chk("ovf_done", 32'(load_done), 32'd0);
        chk("ovf_writes", 32'(wr_cnt - base), 32'd0);

        // Empty image, correct and wrong checksum
        do_reset();
        base = wr_cnt;
        img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_img(1'b0);
        chk("n0_done", 32'(load_done), 32'd1);
        chk("n0_core", 32'(core_rst_n), 32'd1);
        chk("n0_writes", 32'(wr_cnt - base), 32'd0);
        do_reset();
        img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A};
        send_img(1'b0);
        idle(1);
        chk("n0_bad_err", 32'(load_error), 32'd1);
        chk("n0_bad_done", 32'(load_done), 32'd0);

        // One word with idle gaps: 78^56^34^12 = 08
        do_reset();
        base = wr_cnt;
        exp_q.push_back('{32'h0, 32'h1234_5678});
        img = '{8'h01, 8'h00, 8'h00, 8'h00,
                8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_img(1'b1);
        chk("gap_done", 32'(load_done), 32'd1);
        chk("gap_writes", 32'(wr_cnt - base), 32'd1);
        chk("sb_empty_gap", 32'(exp_q.size()), 32'd0);

        // Reset mid-image, then a clean reload
        do_reset();
        img = '{8'h03, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        send_img(1'b0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_rdy", 32'(rx_ready), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        idle(1);
        do_reset();
        base = wr_cnt;
        exp_q.push_back('{32'h0, 32'h0000_0013});
        exp_q.push_back('{32'h4, 32'h0010_0093});
        img = '{8'h02, 8'h00, 8'h00, 8'h00,
                8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_img(1'b0);
        chk("reload_done", 32'(load_done), 32'd1);
        chk("reload_writes", 32'(wr_cnt - base), 32'd2);
        idle(2);
        chk("sb_empty_end", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
